// File: rtl/booth_mult_param.sv
// Multi-cycle radix-4 Booth multiplier with start/ready handshake.
// Produces the full 2*WIDTH product and a mode-dependent overflow flag.
module booth_mult_param #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_result_hi,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int N  = WIDTH / 2 + 1;
  localparam int CW = $clog2(N + 1);
  localparam int EW = WIDTH + 2;
  localparam int AW = WIDTH + 4;
  localparam logic [CW-1:0] LAST_STEP = CW'(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [EW-1:0]    mcand_q, mcand_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [EW-1:0]    mplr_q, mplr_d;
  logic             ghost_q, ghost_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic [AW-1:0]      a_ext, a_dbl, addend, acc_sum;
  logic [EW-1:0]      op_a_ext, op_b_ext;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     prod_top;
  logic               exc_next;

  always_comb begin
    op_a_ext = is_signed ? {{2{data_operandA[WIDTH-1]}}, data_operandA}
                         : {2'b00, data_operandA};
    op_b_ext = is_signed ? {{2{data_operandB[WIDTH-1]}}, data_operandB}
                         : {2'b00, data_operandB};

    a_ext = {{2{mcand_q[EW-1]}}, mcand_q};
    a_dbl = {a_ext[AW-2:0], 1'b0};
    case ({mplr_q[1:0], ghost_q})
      3'b001, 3'b010: addend = a_ext;
      3'b011:         addend = a_dbl;
      3'b100:         addend = -a_dbl;
      3'b101, 3'b110: addend = -a_ext;
      default:        addend = '0;
    endcase
    acc_sum = acc_q + addend;

    // The product lives in the low 2*WIDTH bits of {acc, mplr} once all steps are done
    product  = {acc_q[WIDTH-3:0], mplr_q};
    prod_top = product[2*WIDTH-1:WIDTH-1];
    exc_next = mode_q ? !((&prod_top) || (~|prod_top))
                      : (|product[2*WIDTH-1:WIDTH]);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplr_d   = mplr_q;
    ghost_d  = ghost_q;
    mode_d   = mode_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    exc_d    = exc_q;
    rdy_d    = rdy_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mcand_d = op_a_ext;
          mplr_d  = op_b_ext;
          acc_d   = '0;
          ghost_d = 1'b0;
          mode_d  = is_signed;
          cnt_d   = '0;
          rdy_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q != LAST_STEP) begin
          acc_d   = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};
          mplr_d  = {acc_sum[1:0], mplr_q[EW-1:2]};
          ghost_d = mplr_q[1];
          cnt_d   = cnt_q + CW'(1);
        end else begin
          res_lo_d = product[WIDTH-1:0];
          res_hi_d = product[2*WIDTH-1:WIDTH];
          exc_d    = exc_next;
          rdy_d    = 1'b1;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplr_q   <= '0;
      ghost_q  <= 1'b0;
      mode_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplr_q   <= mplr_d;
      ghost_q  <= ghost_d;
      mode_q   <= mode_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = res_lo_q;
  assign data_result_hi = res_hi_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = (state_q == S_RUN);

endmodule
